// File: rtl/cfu_sched_pkg.sv
// Shared constants and types for the two-port CFU scheduler.
package cfu_sched_pkg;

  localparam int NUM_REQ_PORTS       = 2;
  localparam int MAX_OUTSTANDING_DEF = 4;

  localparam int CFU_ID_W     = 8;
  localparam int CFU_SEL_W    = 3;
  localparam int CFU_FUNC_W   = 7;
  localparam int CFU_DATA_W   = 32;
  localparam int CFU_STATUS_W = 2;

  typedef logic port_idx_t;

  typedef enum logic {
    GRANT_OPEN   = 1'b0,
    GRANT_LOCKED = 1'b1
  } grant_state_t;

endpackage

// File: rtl/cfu_interface.sv
// Request/response bundle between a requester and a CFU datapath.
interface cfu_interface;
  import cfu_sched_pkg::*;

  logic                    req_valid;
  logic                    req_ready;
  logic [CFU_ID_W-1:0]     req_id;
  logic [CFU_SEL_W-1:0]    req_cfu;
  logic [CFU_FUNC_W-1:0]   req_func;
  logic [CFU_DATA_W-1:0]   req_data0;
  logic [CFU_DATA_W-1:0]   req_data1;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [CFU_ID_W-1:0]     resp_id;
  logic [CFU_STATUS_W-1:0] resp_status;
  logic [CFU_DATA_W-1:0]   resp_data;

  modport master (
    output req_valid, req_id, req_cfu, req_func, req_data0, req_data1, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_status, resp_data
  );

  modport slave (
    input  req_valid, req_id, req_cfu, req_func, req_data0, req_data1, resp_ready,
    output req_ready, resp_valid, resp_id, resp_status, resp_data
  );

endinterface

// File: rtl/cfu_route_fifo.sv
// Small FIFO remembering which requester owns each outstanding CFU request.
module cfu_route_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers are PW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cfu_scheduler.sv
// Round-robin sharing of one CFU between two requesters, with in-order
// response routing via a FIFO of owner indices.
module cfu_scheduler
  import cfu_sched_pkg::*;
#(
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
  input  logic          clk,
  input  logic          rst,
  cfu_interface.slave   req0,
  cfu_interface.slave   req1,
  cfu_interface.master  cfu
);

  grant_state_t state_q;
  port_idx_t    grant_q;
  port_idx_t    prio_q;
  port_idx_t    grant;
  port_idx_t    head;
  logic         rst_done_q;
  logic         fifo_full;
  logic         fifo_empty;
  logic         issue_ok;
  logic         sel_valid;
  logic         accept;
  logic         resp_pop;

  // A lone valid requester wins immediately; prio_q only breaks ties.
  always_comb begin
    grant = prio_q;
    if (state_q == GRANT_LOCKED)                 grant = grant_q;
    else if (req0.req_valid && !req1.req_valid)  grant = 1'b0;
    else if (req1.req_valid && !req0.req_valid)  grant = 1'b1;
  end

  assign issue_ok      = rst_done_q && !fifo_full;
  assign sel_valid     = grant ? req1.req_valid : req0.req_valid;
  assign cfu.req_valid = sel_valid && issue_ok;
  assign cfu.req_id    = grant ? req1.req_id    : req0.req_id;
  assign cfu.req_cfu   = grant ? req1.req_cfu   : req0.req_cfu;
  assign cfu.req_func  = grant ? req1.req_func  : req0.req_func;
  assign cfu.req_data0 = grant ? req1.req_data0 : req0.req_data0;
  assign cfu.req_data1 = grant ? req1.req_data1 : req0.req_data1;
  assign req0.req_ready = !grant && issue_ok && cfu.req_ready;
  assign req1.req_ready =  grant && issue_ok && cfu.req_ready;
  assign accept         = cfu.req_valid && cfu.req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= GRANT_OPEN;
      grant_q    <= 1'b0;
      prio_q     <= 1'b0;
      rst_done_q <= 1'b0;
    end else begin
      rst_done_q <= 1'b1;
      case (state_q)
        GRANT_OPEN:
          if (cfu.req_valid && !cfu.req_ready) begin
            state_q <= GRANT_LOCKED;
            grant_q <= grant;
          end
        GRANT_LOCKED:
          if (!cfu.req_valid || cfu.req_ready) state_q <= GRANT_OPEN;
        default: state_q <= GRANT_OPEN;
      endcase
      if (accept) prio_q <= ~grant;
    end
  end

  cfu_route_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (1)
  ) u_route_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (resp_pop),
    .wdata (grant),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Responses with no owner on record are swallowed.
  assign req0.resp_valid = !fifo_empty && !head && cfu.resp_valid;
  assign req1.resp_valid = !fifo_empty &&  head && cfu.resp_valid;
  assign cfu.resp_ready  = fifo_empty ? 1'b1 : (head ? req1.resp_ready : req0.resp_ready);
  assign resp_pop        = cfu.resp_valid && cfu.resp_ready && !fifo_empty;

  assign req0.resp_id     = cfu.resp_id;
  assign req0.resp_status = cfu.resp_status;
  assign req0.resp_data   = cfu.resp_data;
  assign req1.resp_id     = cfu.resp_id;
  assign req1.resp_status = cfu.resp_status;
  assign req1.resp_data   = cfu.resp_data;

endmodule

// File: tb/tb_cfu_scheduler.sv
// Bench for cfu_scheduler: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cfu_scheduler;
  import cfu_sched_pkg::*;

  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cfu_interface r0 ();
  cfu_interface r1 ();
  cfu_interface c ();

  cfu_scheduler #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst), .req0(r0), .req1(r1), .cfu(c)
  );

  logic        pv [2];
  logic [7:0]  pid [2];
  logic [2:0]  pcfu [2];
  logic [6:0]  pfunc [2];
  logic [31:0] pd0 [2];
  logic [31:0] pd1 [2];
  logic        prr [2];
  logic        c_req_ready, c_resp_valid;
  logic [7:0]  c_resp_id;
  logic [1:0]  c_resp_status;
  logic [31:0] c_resp_data;

  assign r0.req_valid = pv[0];  assign r1.req_valid = pv[1];
  assign r0.req_id    = pid[0]; assign r1.req_id    = pid[1];
  assign r0.req_cfu   = pcfu[0]; assign r1.req_cfu  = pcfu[1];
  assign r0.req_func  = pfunc[0]; assign r1.req_func = pfunc[1];
  assign r0.req_data0 = pd0[0]; assign r1.req_data0 = pd0[1];
  assign r0.req_data1 = pd1[0]; assign r1.req_data1 = pd1[1];
  assign r0.resp_ready = prr[0]; assign r1.resp_ready = prr[1];
  assign c.req_ready   = c_req_ready;
  assign c.resp_valid  = c_resp_valid;
  assign c.resp_id     = c_resp_id;
  assign c.resp_status = c_resp_status;
  assign c.resp_data   = c_resp_data;

  int n_vec = 0;
  int n_mis = 0;

  // Reference model: owners of outstanding requests, last accepted port, lock.
  int q[$];
  int last_acc;
  int lock_port;
  bit first_cyc;
  int acc_log[$];
  int resp_port_log[$];
  logic [31:0] resp_data_log[$];
  bit acc_now [2];

  logic        s_cvalid, s_r0ready, s_r1ready, s_r0rv, s_r1rv, s_cresp_ready;
  logic [7:0]  s_req_id, s_r0id;
  logic [31:0] s_req_data0, s_r0data, s_r1data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    last_acc  = 1;
    lock_port = -1;
    first_cyc = 1'b1;
  endtask

  task automatic cycle();
    int g, h;
    bit blocked, ev, pop;
    @(negedge clk);
    blocked = (q.size() == MAXO) || first_cyc;
    if (lock_port >= 0)        g = lock_port;
    else if (pv[0] && !pv[1])  g = 0;
    else if (pv[1] && !pv[0])  g = 1;
    else                       g = 1 - last_acc;
    ev = !blocked && pv[g];
    chk("cfu_req_valid", c.req_valid, ev);
    if (ev) begin
      chk("cfu_req_id", c.req_id, pid[g]);
      chk("cfu_req_cfu", c.req_cfu, pcfu[g]);
      chk("cfu_req_func", c.req_func, pfunc[g]);
      chk("cfu_req_data0", c.req_data0, pd0[g]);
      chk("cfu_req_data1", c.req_data1, pd1[g]);
    end
    if (pv[0]) chk("req0_ready", r0.req_ready, (g == 0 && !blocked) ? c_req_ready : 1'b0);
    if (pv[1]) chk("req1_ready", r1.req_ready, (g == 1 && !blocked) ? c_req_ready : 1'b0);
    pop = 1'b0;
    if (q.size() == 0) begin
      chk("cfu_resp_ready_empty", c.resp_ready, 1);
      chk("req0_resp_valid_empty", r0.resp_valid, 0);
      chk("req1_resp_valid_empty", r1.resp_valid, 0);
    end else begin
      h = q[0];
      chk("req0_resp_valid", r0.resp_valid, (h == 0) && c_resp_valid);
      chk("req1_resp_valid", r1.resp_valid, (h == 1) && c_resp_valid);
      chk("cfu_resp_ready", c.resp_ready, prr[h]);
      if (c_resp_valid) begin
        chk("resp_id",     (h == 0) ? r0.resp_id     : r1.resp_id,     c_resp_id);
        chk("resp_status", (h == 0) ? r0.resp_status : r1.resp_status, c_resp_status);
        chk("resp_data",   (h == 0) ? r0.resp_data   : r1.resp_data,   c_resp_data);
      end
      pop = c_resp_valid && prr[h];
    end
    s_cvalid = c.req_valid;  s_req_id = c.req_id;  s_req_data0 = c.req_data0;
    s_r0ready = r0.req_ready; s_r1ready = r1.req_ready;
    s_r0rv = r0.resp_valid;  s_r1rv = r1.resp_valid;  s_cresp_ready = c.resp_ready;
    s_r0id = r0.resp_id;     s_r0data = r0.resp_data;  s_r1data = r1.resp_data;
    if (pop) begin
      resp_port_log.push_back(q[0]);
      resp_data_log.push_back(c_resp_data);
      void'(q.pop_front());
    end
    acc_now[0] = 1'b0;
    acc_now[1] = 1'b0;
    if (ev && c_req_ready) begin
      q.push_back(g);
      acc_log.push_back(g);
      last_acc  = g;
      lock_port = -1;
      acc_now[g] = 1'b1;
    end else if (ev) lock_port = g;
    else             lock_port = -1;
    first_cyc = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pv[0] = 1'b0;
    pv[1] = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_cfu_req_valid", c.req_valid, 0);
    chk("rst_req0_resp_valid", r0.resp_valid, 0);
    chk("rst_req1_resp_valid", r1.resp_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_until_acc(input int n, input int limit);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < limit) begin
      cycle();
      got += int'(acc_now[0]) + int'(acc_now[1]);
      cyc++;
    end
    if (got < n) chk("accept_timeout", got, n);
  endtask

  task automatic drain(input int n);
    pv[0] = 1'b0; pv[1] = 1'b0;
    prr[0] = 1'b1; prr[1] = 1'b1;
    c_resp_valid = 1'b1;
    for (int i = 0; i < n; i++) cycle();
    c_resp_valid = 1'b0;
  endtask

  task automatic rand_payload(input int p);
    pid[p]   = 8'($urandom);
    pcfu[p]  = 3'($urandom);
    pfunc[p] = 7'($urandom);
    pd0[p]   = $urandom;
    pd1[p]   = $urandom;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    for (int p = 0; p < 2; p++) begin
      pv[p] = 1'b0; pid[p] = '0; pcfu[p] = '0; pfunc[p] = '0;
      pd0[p] = '0; pd1[p] = '0; prr[p] = 1'b1;
    end
    c_req_ready = 1'b0; c_resp_valid = 1'b1;
    c_resp_id = 8'h3C; c_resp_status = 2'b01; c_resp_data = 32'hDEAD0000;
    #1;

    // Reset state and the blocked first cycle after release.
    do_reset();
    c_resp_valid = 1'b0;
    c_req_ready = 1'b1;
    pv[0] = 1'b1; pid[0] = 8'h05; pfunc[0] = 7'd0; pd0[0] = 32'h12345678;
    cycle();
    chk("first_cycle_cfu_valid", s_cvalid, 0);
    chk("first_cycle_req0_ready", s_r0ready, 0);

    // Single port request, answered the next cycle.
    cycle();
    chk("single_issue_valid", s_cvalid, 1);
    chk("single_issue_data0", s_req_data0, 32'h12345678);
    chk("single_accepted_port", acc_log[acc_log.size()-1], 0);
    pv[0] = 1'b0;
    c_resp_valid = 1'b1; c_resp_id = 8'h05; c_resp_data = 32'hCAFE0001;
    cycle();
    chk("single_resp_valid0", s_r0rv, 1);
    chk("single_resp_id", s_r0id, 8'h05);
    chk("single_resp_data", s_r0data, 32'hCAFE0001);
    chk("single_resp_valid1", s_r1rv, 0);
    c_resp_valid = 1'b0;

    // Fairness: both valid, CFU always ready, responses drained continuously.
    do_reset();
    pv[0] = 1'b1; pv[1] = 1'b1; pid[0] = 8'hA0; pid[1] = 8'hB1;
    c_req_ready = 1'b1; c_resp_valid = 1'b1;
    base = acc_log.size();
    cycle();
    run_until_acc(8, 40);
    for (int i = 0; i < 8; i++)
      if (base + i < acc_log.size()) chk("fair_grant_order", acc_log[base+i], i % 2);
    drain(6);

    // Back-pressure: grant stays on port 1 while the CFU stalls.
    do_reset();
    c_resp_valid = 1'b0; c_req_ready = 1'b0;
    pv[1] = 1'b1; pid[1] = 8'h11;
    cycle();
    cycle();
    chk("bp_port1_issued", s_req_id, 8'h11);
    pv[0] = 1'b1; pid[0] = 8'h22;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_grant_held", s_req_id, 8'h11);
      chk("bp_req0_not_ready", s_r0ready, 0);
    end
    c_req_ready = 1'b1;
    cycle();
    chk("bp_port1_accept", s_r1ready, 1);
    pv[1] = 1'b0;
    cycle();
    chk("bp_port0_next", s_req_id, 8'h22);
    chk("bp_port0_accept", s_r0ready, 1);
    pv[0] = 1'b0;
    drain(4);

    // Full: four outstanding, fifth waits for a pop and is not taken in the pop cycle.
    do_reset();
    c_resp_valid = 1'b0; c_req_ready = 1'b1; pv[0] = 1'b1;
    cycle();
    run_until_acc(4, 20);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("full_req0_ready", s_r0ready, 0);
      chk("full_cfu_valid", s_cvalid, 0);
    end
    c_resp_valid = 1'b1; prr[0] = 1'b1;
    cycle();
    chk("full_pop_resp", s_r0rv, 1);
    chk("full_pop_no_push", s_r0ready, 0);
    c_resp_valid = 1'b0;
    cycle();
    chk("full_then_accept", s_r0ready, 1);
    pv[0] = 1'b0;
    drain(6);

    // Ordering: accepts 1,0,1 answered A,B,C.
    do_reset();
    c_resp_valid = 1'b0; c_req_ready = 1'b1;
    cycle();
    pv[1] = 1'b1; run_until_acc(1, 5); pv[1] = 1'b0;
    pv[0] = 1'b1; run_until_acc(1, 5); pv[0] = 1'b0;
    pv[1] = 1'b1; run_until_acc(1, 5); pv[1] = 1'b0;
    base = resp_port_log.size();
    c_resp_valid = 1'b1;
    c_resp_data = 32'hA; cycle();
    chk("ord_first_p1", s_r1rv, 1); chk("ord_first_p0", s_r0rv, 0); chk("ord_first_data", s_r1data, 32'hA);
    c_resp_data = 32'hB; cycle();
    chk("ord_second_p0", s_r0rv, 1); chk("ord_second_p1", s_r1rv, 0); chk("ord_second_data", s_r0data, 32'hB);
    c_resp_data = 32'hC; cycle();
    chk("ord_third_p1", s_r1rv, 1); chk("ord_third_data", s_r1data, 32'hC);
    c_resp_valid = 1'b0;
    if (resp_port_log.size() == base + 3) begin
      chk("ord_log_port0", resp_port_log[base], 1);
      chk("ord_log_port1", resp_port_log[base+1], 0);
      chk("ord_log_port2", resp_port_log[base+2], 1);
    end else chk("ord_log_size", resp_port_log.size(), base + 3);

    // Reset with three outstanding; the late response is an orphan.
    pv[0] = 1'b1;
    run_until_acc(3, 10);
    pv[0] = 1'b0;
    do_reset();
    c_resp_valid = 1'b1; c_resp_data = 32'h77;
    cycle();
    chk("orphan_no_resp0", s_r0rv, 0);
    chk("orphan_no_resp1", s_r1rv, 0);
    chk("orphan_dropped", s_cresp_ready, 1);
    c_resp_valid = 1'b0;
    pv[0] = 1'b1;
    run_until_acc(4, 10);
    cycle();
    chk("post_reset_occupancy_full_at_4", s_r0ready, 0);
    drain(6);

    // Randomized traffic with one reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      for (int p = 0; p < 2; p++) begin
        if (!pv[p] && $urandom_range(0, 2) == 0) begin
          pv[p] = 1'b1;
          rand_payload(p);
        end
        prr[p] = ($urandom_range(0, 3) != 0);
      end
      c_req_ready   = ($urandom_range(0, 3) != 0);
      c_resp_valid  = ($urandom_range(0, 1) == 1);
      c_resp_id     = 8'($urandom);
      c_resp_status = 2'($urandom);
      c_resp_data   = $urandom;
      cycle();
      for (int p = 0; p < 2; p++)
        if (acc_now[p]) begin
          pv[p] = ($urandom_range(0, 1) == 1);
          rand_payload(p);
        end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/cfu_scheduler.md
CFU_SCHEDULER -- requirements
Module: cfu_scheduler

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 4, SHALL set the maximum number of accepted-but-unanswered requests (power of two, 2..16).
REQ-002 Port clk, input, 1 bit: sole clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1 bit: SHALL be an asynchronous, active-high reset.
REQ-004 Port req0, cfu_interface.slave: requester 0, full CFU request/response bundle.
REQ-005 Port req1, cfu_interface.slave: requester 1, full CFU request/response bundle.
REQ-006 Port cfu, cfu_interface.master: the single shared CFU datapath.

Function
REQ-007 Block SHALL arbitrate req0/req1 onto cfu round-robin; after a request from port N is accepted downstream, port N SHALL become lowest priority.
REQ-008 Request path SHALL be zero-latency combinational: cfu.req_valid = granted port's req_valid AND not route-FIFO-full.
REQ-009 cfu.req_id, req_cfu, req_func, req_data0, req_data1 SHALL be driven from the granted port, unmodified.
REQ-010 Only the granted port's req_ready SHALL mirror cfu.req_ready (gated by not-full); the other port's req_ready SHALL be 0.
REQ-011 Grant SHALL lock from the cycle cfu.req_valid rises until cfu.req_valid AND cfu.req_ready; no re-arbitration while locked.
REQ-012 With the grant unlocked and exactly one port valid, that port SHALL be granted the same cycle, regardless of the priority pointer.
REQ-013 Each downstream accept SHALL push the granted port index (1 bit) into a route FIFO of depth MAX_OUTSTANDING.
REQ-014 With the FIFO full, no new request SHALL be issued; req0/req1 req_ready SHALL be 0.
REQ-015 Push while full SHALL NOT occur; simultaneous push and pop while not full and not empty SHALL leave the occupancy unchanged.
REQ-016 Simultaneous pop and push at full SHALL NOT allow the push that cycle (full is evaluated from registered occupancy).
REQ-017 cfu.resp_valid, resp_id, resp_status, resp_data SHALL be routed to the port at the FIFO head; the other port's resp_valid SHALL be 0.
REQ-018 cfu.resp_ready SHALL equal the head port's resp_ready; the FIFO SHALL pop on cfu.resp_valid AND cfu.resp_ready.
REQ-019 cfu.resp_valid while the FIFO is empty SHALL be dropped: cfu.resp_ready = 1, no port resp_valid, no pop.
REQ-020 Responses SHALL be returned in acceptance order; no reordering.
REQ-021 Occupancy counter width SHALL be $clog2(MAX_OUTSTANDING)+1, with no wrap past MAX_OUTSTANDING or below 0.
REQ-022 FIFO read and write pointers SHALL wrap modulo MAX_OUTSTANDING.

Reset
REQ-023 On rst: priority pointer = port 0, grant unlocked, FIFO pointers and occupancy = 0.
REQ-024 During rst and the first cycle after deassertion: cfu.req_valid = 0 and req0/req1 resp_valid = 0.
REQ-025 Reset mid-transaction SHALL discard all outstanding routing entries; later orphan responses SHALL follow REQ-019.

Structure
REQ-026 Package cfu_sched_pkg SHALL hold NUM_REQ_PORTS = 2, typedef port_idx_t (1 bit) and the MAX_OUTSTANDING default constant.
REQ-027 The route FIFO SHALL be a sub-module cfu_route_fifo (parameterised depth and width, full/empty flags, asynchronous active-high reset).
REQ-028 All other logic SHALL be flat inside cfu_scheduler.

Verification
REQ-029 Single-port test: req0 issues func=0, data0=0x12345678 with the CFU answering next cycle; req0 SHALL receive resp_data with matching resp_id, and req1 SHALL see no resp_valid.
REQ-030 Fairness test: both ports valid continuously for 8 requests with CFU always ready; grants SHALL alternate 0,1,0,1..., starting at port 0 after reset.
REQ-031 Back-pressure test: CFU req_ready low for 5 cycles with port1 granted and port0 raising valid meanwhile; the grant SHALL stay on port 1 until accept, then move to port 0.
REQ-032 Full test: with MAX_OUTSTANDING=4, 4 requests are accepted and no response is given; the 5th SHALL see req_ready = 0 until one response pops, then be accepted.
REQ-033 Ordering test: accepts ordered port 1,0,1 with responses data 0xA,0xB,0xC; ports SHALL receive 1:0xA, 0:0xB, 1:0xC in that order.
REQ-034 Reset test: rst is asserted with 3 outstanding, then the CFU returns 1 response; no port SHALL see resp_valid, and occupancy SHALL be 0.
